// File: rtl/io_trace_monitor.sv
// io_trace_monitor: watches CPU I/O writes during a run, timestamps them into a
// small trace FIFO and ends the run on a write to DONE_ADDR or on a cycle limit.
// Optional feature: define IO_TRACE_TS_EN to store the TS_W timestamp with each
// entry (rd_data = {timestamp, addr, data}); otherwise rd_data = {addr, data}.
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | after reset, waiting for start
// RUN     | counting cycles, capturing writes into the FIFO
// DONE    | run ended by a write to DONE_ADDR
// TIMEOUT | run ended after max_cycles RUN cycles
module io_trace_monitor #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter logic [ADDR_W-1:0] DONE_ADDR = '1,
  localparam int LVL_W = $clog2(DEPTH) + 1,
`ifdef IO_TRACE_TS_EN
  localparam int ENTRY_W = TS_W + ADDR_W + DATA_W
`else
  localparam int ENTRY_W = ADDR_W + DATA_W
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [TS_W-1:0]    max_cycles,
  input  logic               io_we,
  input  logic [ADDR_W-1:0]  io_addr,
  input  logic [DATA_W-1:0]  io_data,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [LVL_W-1:0]   level,
  output logic               overflow,
  output logic [TS_W-1:0]    write_count,
  output logic [TS_W-1:0]    cycles,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [TS_W-1:0]  TS_ONE = TS_W'(1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t state_q, state_d;
  logic   clr_run;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0] entry;
  logic               running, done_wr, trace_wr, full, pop, push;

  assign running  = (state_q == S_RUN);
  assign done_wr  = running && io_we && (io_addr == DONE_ADDR);
  assign trace_wr = running && io_we && (io_addr != DONE_ADDR);
  assign full     = (level == FULL_LVL);
  assign pop      = rd_en && (level != '0);
  // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
  assign push     = trace_wr && (!full || pop);

`ifdef IO_TRACE_TS_EN
  assign entry = {cycles, io_addr, io_data};
`else
  assign entry = {io_addr, io_data};
`endif

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign timeout = (state_q == S_TIMEOUT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a done write beats a coinciding timeout.
  always_comb begin
    state_d = state_q;
    clr_run = 1'b0;
    case (state_q)
      S_RUN: begin
        if (done_wr)
          state_d = S_DONE;
        else if ((max_cycles != '0) && (cycles == max_cycles - TS_ONE))
          state_d = S_TIMEOUT;
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          clr_run = 1'b1;
        end
      end
    endcase
  end

  // Run cycle counter and write counter, both saturating.
  always_ff @(posedge clk) begin
    if (reset || clr_run) begin
      cycles      <= '0;
      write_count <= '0;
    end else if (running) begin
      if (cycles != '1) cycles <= cycles + TS_ONE;
      if (trace_wr && (write_count != '1)) write_count <= write_count + TS_ONE;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset || clr_run) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
      if (trace_wr && full && !pop) overflow <= 1'b1;
    end
  end

  // Trace storage; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // Registered read port: data appears the cycle after rd_en and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= mem[rd_ptr];
    end
  end

endmodule
